// File: rtl/seq_gen_pkg.sv
// ============================================================================
// Module : seq_gen_pkg
// Brief  : Mode encodings and default constants for the sequence generator.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package seq_gen_pkg;

  typedef logic [1:0] mode_t;

  localparam mode_t MODE_ROT_L = 2'b00;
  localparam mode_t MODE_ROT_R = 2'b01;
  localparam mode_t MODE_LFSR  = 2'b10;
  localparam mode_t MODE_HOLD  = 2'b11;

  localparam logic [15:0] SEQ_INIT_DEFAULT    = 16'h0D95;
  localparam logic [15:0] TAPS_DEFAULT        = 16'hB400;
  localparam logic [4:0]  DET_PATTERN_DEFAULT = 5'b10110;

endpackage

`default_nettype wire

// File: rtl/seq_det_shift.sv
// ============================================================================
// Module : seq_det_shift
// Brief  : Serial pattern detector; history register plus registered match.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module seq_det_shift import seq_gen_pkg::*; #(
  parameter int               DET_W       = 5,
  parameter logic [DET_W-1:0] DET_PATTERN = DET_W'(DET_PATTERN_DEFAULT)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic step,
  input  logic bit_in,
  output logic hit
);

  localparam int SC_W = (DET_W > 2) ? $clog2(DET_W) : 1;

  logic [DET_W-1:0] hist;
  logic [SC_W-1:0]  steps;
  logic             ready;
  logic [DET_W-1:0] window;

  // A full window needs DET_W bits; this step supplies the last one.
  assign ready  = (steps == SC_W'(DET_W - 1));
  assign window = {hist[DET_W-2:0], bit_in};

  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      hist  <= '0;
      steps <= '0;
      hit   <= 1'b0;
    end else if (step) begin
      hist <= window;
      if (!ready) begin
        steps <= steps + SC_W'(1);
      end
      hit <= ready && (window == DET_PATTERN);
    end else begin
      hit <= 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: rtl/seq_gen_param.sv
// ============================================================================
// Module : seq_gen_param
// Brief  : Parametrised rotating / LFSR sequence generator with period pulse.
//          Optional serial detector enabled by macro SEQ_GEN_DETECT_EN.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module seq_gen_param import seq_gen_pkg::*; #(
  parameter int               WIDTH       = 16,
  parameter logic [WIDTH-1:0] SEQ_INIT    = WIDTH'(SEQ_INIT_DEFAULT),
  parameter logic [WIDTH-1:0] TAPS        = WIDTH'(TAPS_DEFAULT),
  parameter int               LED_W       = 5,
  parameter int               DET_W       = 5,
  parameter logic [DET_W-1:0] DET_PATTERN = DET_W'(DET_PATTERN_DEFAULT)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     load,
  input  logic                     use_ext,
  input  logic [WIDTH-1:0]         load_val,
  input  logic                     en,
  input  logic [1:0]               mode,
  output logic [WIDTH-1:0]         seq,
  output logic                     ser_out,
  output logic [LED_W-1:0]         led,
  output logic [$clog2(WIDTH)-1:0] cnt,
  output logic                     wrap,
  output logic                     det_hit
);

  localparam int CNT_W = $clog2(WIDTH);

  logic [WIDTH-1:0] seq_next;
  logic             step;

  assign step    = en && (mode != MODE_HOLD);
  assign ser_out = (mode == MODE_ROT_R) ? seq[0] : seq[WIDTH-1];
  assign led     = seq[LED_W-1:0];

  always_comb begin
    seq_next = seq;
    case (mode)
      MODE_ROT_L: seq_next = {seq[WIDTH-2:0], seq[WIDTH-1]};
      MODE_ROT_R: seq_next = {seq[0], seq[WIDTH-1:1]};
      // All-zero state would lock the LFSR; escape to 1.
      MODE_LFSR:  seq_next = (seq == '0) ? WIDTH'(1)
                                         : {seq[WIDTH-2:0], ^(seq & TAPS)};
      default:    seq_next = seq;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      seq  <= SEQ_INIT;
      cnt  <= '0;
      wrap <= 1'b0;
    end else if (load) begin
      seq  <= use_ext ? load_val : SEQ_INIT;
      cnt  <= '0;
      wrap <= 1'b0;
    end else if (step) begin
      seq  <= seq_next;
      wrap <= (cnt == CNT_W'(WIDTH - 1));
      cnt  <= (cnt == CNT_W'(WIDTH - 1)) ? '0 : cnt + CNT_W'(1);
    end else begin
      wrap <= 1'b0;
    end
  end

`ifdef SEQ_GEN_DETECT_EN
  seq_det_shift #(
    .DET_W       (DET_W),
    .DET_PATTERN (DET_PATTERN)
  ) u_det (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (load),
    .step   (step),
    .bit_in (ser_out),
    .hit    (det_hit)
  );
`else
  logic unused_det_cfg;
  assign unused_det_cfg = ^{DET_PATTERN, DET_W[0]};
  assign det_hit        = 1'b0;
`endif

endmodule

`default_nettype wire
